if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage of the pipelined RISC-V SCPU, directly upstream of the IF/ID pipeline register. It owns the architectural PC, drives a req/ack handshake to instruction memory, and applies branch/jump redirects from EX. It also honours hazard stalls and presents a one-entry registered {PC, instruction, valid} to IF/ID. A watchdog halts fetch and flags an error if instruction memory never acknowledges.

Parameters:
RESET_PC, 32'h00000000, PC fetched first after reset.
TIMEOUT, 16, consecutive unacknowledged req cycles before halt; 0 disables the watchdog.
NOP_INST, 32'h00000013, instruction word presented when the output is invalid (addi x0,x0,0).

Ports:
clk_IF  input  1  pipeline clock; all state updates on rising edge.
rst_n_IF  input  1  reset, asynchronous, active-low.
stall_IF  input  1  hazard stall from hazard unit; IF/ID does not consume this cycle.
redirect_IF  input  1  taken branch/jump from EX.
redirect_PC_IF  input  32  redirect target.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address (= internal pc register).
imem_ack  input  1  memory accepts the request and returns data this cycle.
imem_rdata  input  32  instruction word, valid when imem_req && imem_ack.
PC_out_IF  output  32  PC of the buffered instruction, to IF/ID PC_in.
inst_out_IF  output  32  buffered instruction, to IF/ID inst_in.
valid_IF  output  1  buffered instruction is valid.
fetch_err_IF  output  1  watchdog timeout (sticky until redirect or reset).

Behaviour:
- Reset (rst_n_IF=0, takes effect immediately, no clock needed): pc=RESET_PC, state=BOOT, PC_out_IF=0, inst_out_IF=NOP_INST, valid_IF=0, fetch_err_IF=0, watchdog count=0. imem_req=0 during reset.
- States: BOOT (req=0; one cycle, then FETCH), FETCH (normal), HALT (req=0; exits only on redirect or reset).
- can_accept = !valid_IF || !stall_IF.
- imem_req = (state==FETCH) && can_accept && !redirect_IF (combinational). imem_addr = pc at all times.
- Consume: rising edge with valid_IF=1 and stall_IF=0 means IF/ID took the entry. If no capture occurs on the same edge, valid_IF<=0, inst_out_IF<=NOP_INST, PC_out_IF<=0.
- Capture: rising edge with imem_req && imem_ack sets PC_out_IF<=pc, inst_out_IF<=imem_rdata, valid_IF<=1, pc<=pc+4. The PC wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- Throughput: with a zero-wait memory (ack tied high), one instruction per cycle. First valid_IF rises on the second rising edge after reset deassertion.
- Stall with valid_IF=1: imem_req=0, pc unchanged, and PC_out_IF/inst_out_IF/valid_IF held.
- Wait states: while imem_req=1 and imem_ack=0, pc and imem_addr are held stable and valid_IF is cleared by the normal consume rule.
- Redirect (priority above stall, capture, watchdog, and HALT): on the edge with redirect_IF=1:
  - pc<={redirect_PC_IF[31:2],2'b00}; low address bits are ignored.
  - valid_IF<=0, inst_out_IF<=NOP_INST, PC_out_IF<=0; the buffered entry is flushed even if stalled.
  - fetch_err_IF<=0, watchdog<=0, state<=FETCH.
  - No capture can occur that cycle because imem_req is gated low.
- Watchdog (TIMEOUT>0):
  - Counts edges where imem_req=1 and imem_ack=0; cleared on capture, on redirect, and on any edge with imem_req=0.
  - When the count reaches TIMEOUT: state<=HALT, fetch_err_IF<=1, imem_req drops next cycle.
  - A valid entry already buffered stays until consumed.
- Simultaneous consume and capture on one edge: the new entry replaces the old and valid_IF stays 1.
- Reset asserted mid-transaction abandons the request; memory must tolerate req dropping.

Test Plan:
1. Release reset with imem_ack=1 and imem_rdata=f(addr) -> imem_addr 0,4,8,... each cycle; valid_IF=1 from the second edge; PC_out_IF 0,4,8 with matching inst_out_IF.
2. After capture at PC 0x8, hold stall_IF=1 for 3 cycles -> imem_req=0, PC_out_IF=0x8, inst held, imem_addr=0xC. Release -> fetch of 0xC proceeds the next cycle.
3. imem_ack low for 3 cycles at addr 0x10 -> imem_req=1 with addr 0x10 stable and valid_IF=0. On ack -> PC_out_IF=0x10 and imem_addr=0x14.
4. redirect_IF=1 with target 0x103 while stall_IF=1 and valid_IF=1 -> next cycle valid_IF=0, inst_out_IF=0x00000013, imem_addr=0x100, imem_req=1.
5. imem_ack held 0 -> after 16 request cycles fetch_err_IF=1 and imem_req=0, staying that way. Redirect to 0x200 -> fetch_err_IF=0 and fetch resumes at 0x200.
6. RESET_PC=0xFFFFFFFC, ack high -> addresses 0xFFFFFFFC then 0x0. Assert rst_n_IF=0 mid-wait -> outputs hold their reset values before the next clock edge.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, fetches over req/ack, applies redirects and stalls,
// and buffers one {PC, instruction, valid} entry for IF/ID, with a fetch watchdog.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_IF,
  input  logic        rst_n_IF,
  input  logic        stall_IF,
  input  logic        redirect_IF,
  input  logic [31:0] redirect_PC_IF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out_IF,
  output logic [31:0] inst_out_IF,
  output logic        valid_IF,
  output logic        fetch_err_IF
);
  typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_out_q, pc_out_d, inst_q, inst_d, wd_q, wd_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic        can_accept, capture, consume;
  assign can_accept   = !valid_q || !stall_IF;
  assign imem_req     = (state_q == FETCH) && can_accept && !redirect_IF;
  assign imem_addr    = pc_q;
  assign capture      = imem_req && imem_ack;
  assign consume      = valid_q && !stall_IF;
  assign PC_out_IF    = pc_out_q;
  assign inst_out_IF  = inst_q;
  assign valid_IF     = valid_q;
  assign fetch_err_IF = err_q;
  always_comb begin
    state_d  = (state_q == BOOT) ? FETCH : state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    err_d    = err_q;
    wd_d     = imem_req ? wd_q : 32'd0;
    if (capture) begin
      pc_d     = pc_q + 32'd4;
      pc_out_d = pc_q;
      inst_d   = imem_rdata;
      valid_d  = 1'b1;
      wd_d     = 32'd0;
    end else if (consume) begin
      pc_out_d = 32'd0;
      inst_d   = NOP_INST;
      valid_d  = 1'b0;
    end
    // A stuck request counts toward the watchdog; reaching the limit parks fetch in HALT.
    if (TIMEOUT > 0 && imem_req && !imem_ack) begin
      wd_d = wd_q + 32'd1;
      if (wd_d == TIMEOUT) begin
        state_d = HALT;
        err_d   = 1'b1;
      end
    end
    if (redirect_IF) begin
      pc_d     = {redirect_PC_IF[31:2], 2'b00};
      pc_out_d = 32'd0;
      inst_d   = NOP_INST;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      wd_d     = 32'd0;
      state_d  = FETCH;
    end
  end
  always_ff @(posedge clk_IF or negedge rst_n_IF) begin
    if (!rst_n_IF) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      pc_out_q <= 32'd0;
      inst_q   <= NOP_INST;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: table-driven, hand-written and randomized model-checked bench for if_fetch_unit.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redir = 1'b0, ack = 1'b0;
  logic [31:0] rpc = 32'd0, rdata = 32'd0;
  logic        req0, v0, err0, req1, v1, err1;
  logic [31:0] addr0, pco0, inst0, addr1, pco1, inst1;
  int checks = 0, errors = 0;

  if_fetch_unit dut0 (
    .clk_IF(clk), .rst_n_IF(rst_n), .stall_IF(stall), .redirect_IF(redir), .redirect_PC_IF(rpc),
    .imem_req(req0), .imem_addr(addr0), .imem_ack(ack), .imem_rdata(rdata),
    .PC_out_IF(pco0), .inst_out_IF(inst0), .valid_IF(v0), .fetch_err_IF(err0));

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk_IF(clk), .rst_n_IF(rst_n), .stall_IF(stall), .redirect_IF(redir), .redirect_PC_IF(rpc),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(ack), .imem_rdata(rdata),
    .PC_out_IF(pco1), .inst_out_IF(inst1), .valid_IF(v1), .fetch_err_IF(err1));

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of the fetch stage
  logic [31:0] m_pc, m_pco, m_inst;
  logic        m_valid, m_err, m_halt, m_boot;
  int          m_wait;

  function automatic logic m_req();
    return !m_boot && !m_halt && (!m_valid || !stall) && !redir;
  endfunction

  task automatic m_reset(input logic [31:0] pc0);
    m_pc = pc0; m_pco = 0; m_inst = NOP; m_valid = 0; m_err = 0;
    m_halt = 0; m_boot = 1; m_wait = 0;
  endtask

  task automatic m_edge();
    logic r;
    r = m_req();
    if (redir) begin
      m_pc = rpc & ~32'd3; m_valid = 0; m_inst = NOP; m_pco = 0;
      m_err = 0; m_wait = 0; m_halt = 0; m_boot = 0;
    end else begin
      m_boot = 0;
      if (r && ack) begin
        m_pco = m_pc; m_inst = rdata; m_valid = 1; m_pc = m_pc + 4; m_wait = 0;
      end else if (m_valid && !stall) begin
        m_valid = 0; m_inst = NOP; m_pco = 0;
      end
      if (r && !ack) begin
        m_wait++;
        if (m_wait == 16) begin m_halt = 1; m_err = 1; end
      end else if (!r) m_wait = 0;
    end
  endtask

  task automatic check_model();
    chk("req", {31'd0, req0}, {31'd0, m_req()});
    chk("addr", addr0, m_pc);
    chk("valid", {31'd0, v0}, {31'd0, m_valid});
    chk("pc_out", pco0, m_pco);
    chk("inst", inst0, m_inst);
    chk("err", {31'd0, err0}, {31'd0, m_err});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; stall = 0; redir = 0; ack = 0; rpc = 0;
    #1;
    chk("rst_req", {31'd0, req0}, 32'd0);
    chk("rst_valid", {31'd0, v0}, 32'd0);
    chk("rst_inst", inst0, NOP);
    chk("rst_pco", pco0, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_addr", addr0, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic stall, redir; logic [31:0] rpc; logic ack;
    logic req; logic [31:0] addr; logic v; logic [31:0] pco;
  } vec_t;
  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'hC,   1'b1, 32'h8};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'hC,   1'b1, 32'h8};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'hC,   1'b1, 32'h8};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h8};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b1, 32'hC};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 32'h103, 1'b1, 1'b0, 32'h14,  1'b1, 32'h10};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h100};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      stall = vecs[i].stall; redir = vecs[i].redir; rpc = vecs[i].rpc;
      ack = vecs[i].ack; rdata = f(vecs[i].addr);
      #1;
      chk($sformatf("vec%0d_req", i), {31'd0, req0}, {31'd0, vecs[i].req});
      chk($sformatf("vec%0d_addr", i), addr0, vecs[i].addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, v0}, {31'd0, vecs[i].v});
      chk($sformatf("vec%0d_pco", i), pco0, vecs[i].pco);
      chk($sformatf("vec%0d_inst", i), inst0, vecs[i].v ? f(vecs[i].pco) : NOP);
      chk($sformatf("vec%0d_err", i), {31'd0, err0}, 32'd0);
      cyc();
    end

    // Watchdog: 16 unacknowledged request edges halt fetch until a redirect
    stall = 0; redir = 0; ack = 0; rdata = f(32'h108);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("wd_req", {31'd0, req0}, 32'd1);
      chk("wd_addr", addr0, 32'h108);
      chk("wd_err", {31'd0, err0}, 32'd0);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_err", {31'd0, err0}, 32'd1);
      chk("halt_req", {31'd0, req0}, 32'd0);
      chk("halt_valid", {31'd0, v0}, 32'd0);
      cyc();
    end
    redir = 1; rpc = 32'h200;
    #1;
    chk("redir_req_gated", {31'd0, req0}, 32'd0);
    cyc();
    redir = 0; ack = 1; rdata = f(32'h200);
    #1;
    chk("resume_err", {31'd0, err0}, 32'd0);
    chk("resume_req", {31'd0, req0}, 32'd1);
    chk("resume_addr", addr0, 32'h200);
    cyc();
    #1;
    chk("resume_valid", {31'd0, v0}, 32'd1);
    chk("resume_pco", pco0, 32'h200);
    chk("resume_inst", inst0, f(32'h200));

    // Randomized traffic against the reference model; sparse acks late on force halts
    do_reset();
    m_reset(32'h0);
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      redir = ($urandom_range(0, 99) < ((i < 300) ? 5 : 2));
      rpc   = $urandom;
      ack   = ($urandom_range(0, 9) < ((i < 300) ? 7 : 1));
      rdata = f(m_pc) ^ {16'd0, 16'(i)};
      #1;
      check_model();
      m_edge();
      cyc();
    end

    // PC wrap with RESET_PC = 0xFFFFFFFC, then asynchronous reset mid-wait
    do_reset();
    stall = 0; redir = 0; ack = 1; rdata = f(32'hFFFF_FFFC);
    #1;
    chk("wrap_boot_req", {31'd0, req1}, 32'd0);
    chk("wrap_boot_addr", addr1, 32'hFFFF_FFFC);
    cyc();
    #1;
    chk("wrap_req", {31'd0, req1}, 32'd1);
    chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
    cyc();
    #1;
    chk("wrap_addr1", addr1, 32'h0);
    chk("wrap_valid", {31'd0, v1}, 32'd1);
    chk("wrap_pco", pco1, 32'hFFFF_FFFC);
    chk("wrap_inst", inst1, f(32'hFFFF_FFFC));
    ack = 0;
    cyc();
    #1;
    chk("wait_req", {31'd0, req1}, 32'd1);
    chk("wait_valid", {31'd0, v1}, 32'd0);
    #1;
    rst_n = 0;
    #1;
    chk("async_req", {31'd0, req1}, 32'd0);
    chk("async_addr", addr1, 32'hFFFF_FFFC);
    chk("async_valid", {31'd0, v1}, 32'd0);
    chk("async_pco", pco1, 32'd0);
    chk("async_inst", inst1, NOP);
    chk("async_err", {31'd0, err1}, 32'd0);
    chk("async_addr_dut0", addr0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
